// File: rtl/key_repeat.sv
// Turns decoder key levels into single-cycle game command strobes.
// Movement keys (4..6) auto-repeat after a hold delay; keys 1..3 fire once per press.
module key_repeat #(
    parameter int DAS_DELAY  = 17_000_000,
    parameter int ARR_PERIOD = 5_000_000,
    parameter int CNT_W      = 25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] key,
    output logic       cmd_valid,
    output logic [2:0] cmd,
    output logic       cmd_repeat,
    output logic [2:0] held
);

    typedef enum logic [1:0] {IDLE, HOLD, DELAY, REPEAT} state_t;

    localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_DELAY - 1);
    localparam logic [CNT_W-1:0] ARR_LAST = CNT_W'(ARR_PERIOD - 1);

    state_t           state, state_n;
    logic [2:0]       cur, cur_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             valid_n, rep_n;
    logic [2:0]       cmd_n;

    logic active, press, expire;

    assign active = (key != 3'd0) && (key != 3'd7);
    assign press  = active && (key != cur);
    assign expire = ((state == DELAY)  && (cnt == DAS_LAST)) ||
                    ((state == REPEAT) && (cnt == ARR_LAST));
    assign held   = cur;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cur        <= '0;
            cnt        <= '0;
            cmd_valid  <= 1'b0;
            cmd        <= '0;
            cmd_repeat <= 1'b0;
        end else begin
            state      <= state_n;
            cur        <= cur_n;
            cnt        <= cnt_n;
            cmd_valid  <= valid_n;
            cmd        <= cmd_n;
            cmd_repeat <= rep_n;
        end
    end

    // Press/release take priority over counter expiry in the same cycle.
    always_comb begin
        state_n = state;
        cur_n   = cur;
        cnt_n   = cnt;
        if (press) begin
            cur_n   = key;
            cnt_n   = '0;
            state_n = (key >= 3'd4) ? DELAY : HOLD;
        end else if (!active) begin
            cur_n   = '0;
            cnt_n   = '0;
            state_n = IDLE;
        end else if (state == DELAY || state == REPEAT) begin
            if (expire) begin
                cnt_n   = '0;
                state_n = REPEAT;
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end
    end

    always_comb begin
        valid_n = 1'b0;
        rep_n   = 1'b0;
        cmd_n   = cmd;
        if (press) begin
            valid_n = 1'b1;
            cmd_n   = key;
        end else if (active && expire) begin
            valid_n = 1'b1;
            rep_n   = 1'b1;
            cmd_n   = cur;
        end
    end

endmodule

// File: tb/tb_key_repeat.sv
// Bench for key_repeat: directed scenarios then random key segments, compared
// against a model that derives strobe times from press time arithmetic.
module tb_key_repeat;

    localparam int DAS = 8;
    localparam int ARR = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] key;
    logic       cmd_valid;
    logic [2:0] cmd;
    logic       cmd_repeat;
    logic [2:0] held;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // model state: key being tracked and the cycle of its press strobe
    logic [2:0] m_cur = '0;
    int         m_t0  = 0;
    logic       e_valid, e_rep;
    logic [2:0] e_cmd = '0;

    key_repeat #(.DAS_DELAY(DAS), .ARR_PERIOD(ARR), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .key(key),
        .cmd_valid(cmd_valid), .cmd(cmd), .cmd_repeat(cmd_repeat), .held(held)
    );

    always #5 clk = ~clk;

    function automatic logic is_active(input logic [2:0] k);
        return (k != 3'd0) && (k != 3'd7);
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input logic [2:0] k, input logic r);
        int d;
        key = k;
        rst = r;
        @(posedge clk);
        cyc++;
        e_valid = 1'b0;
        e_rep   = 1'b0;
        if (r) begin
            m_cur = '0;
            e_cmd = '0;
        end else if (is_active(k) && k != m_cur) begin
            m_cur   = k;
            m_t0    = cyc;
            e_valid = 1'b1;
            e_cmd   = k;
        end else if (!is_active(k)) begin
            m_cur = '0;
        end else if (m_cur >= 3'd4) begin
            d = cyc - m_t0;
            if (d >= DAS && ((d - DAS) % ARR) == 0) begin
                e_valid = 1'b1;
                e_rep   = 1'b1;
                e_cmd   = m_cur;
            end
        end
        #1;
        chk("cmd_valid", {3'b0, cmd_valid}, {3'b0, e_valid});
        chk("cmd_repeat", {3'b0, cmd_repeat}, {3'b0, e_rep});
        chk("cmd", {1'b0, cmd}, {1'b0, e_cmd});
        chk("held", {1'b0, held}, {1'b0, m_cur});
    endtask

    task automatic run(input logic [2:0] k, input int n);
        for (int i = 0; i < n; i++) step(k, 1'b0);
    endtask

    initial begin
        // reset held with key=5, then fresh press on release of reset
        for (int i = 0; i < 3; i++) step(3'd5, 1'b1);
        run(3'd5, 4);
        run(3'd0, 3);
        // one-shot key
        run(3'd2, 40);
        run(3'd0, 3);
        // auto-repeat
        run(3'd6, 20);
        run(3'd0, 5);
        // direct switch left -> right
        run(3'd5, 5);
        run(3'd6, 15);
        run(3'd0, 3);
        // expiry collision with release
        run(3'd4, 8);
        step(3'd0, 1'b0);
        run(3'd0, 3);
        // expiry collision with new press
        run(3'd4, 8);
        run(3'd3, 4);
        run(3'd0, 2);
        // other/none
        run(3'd7, 10);
        run(3'd0, 3);
        // alternating codes every cycle
        for (int i = 0; i < 6; i++) step((i % 2) ? 3'd4 : 3'd1, 1'b0);
        // reset mid-repeat
        run(3'd5, 12);
        step(3'd5, 1'b1);
        run(3'd5, 12);
        // random segments
        for (int s = 0; s < 80; s++) begin
            logic [2:0] k;
            int n;
            k = 3'($urandom_range(0, 7));
            n = $urandom_range(1, 25);
            if ($urandom_range(0, 19) == 0) step(k, 1'b1);
            run(k, n);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
